// File: rtl/data_mem_ctrl.sv
// Data memory controller: single-port word array fronted by an in-order store buffer.
// Define DMEM_FWD_EN for store-to-load forwarding; otherwise a matching load stalls until its store retires.
module data_mem_ctrl #(
    parameter int A_SIZE   = 10,
    parameter int D_SIZE   = 32,
    parameter int WB_DEPTH = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        read,
    input  logic                        write,
    input  logic [A_SIZE-1:0]           address,
    input  logic [D_SIZE-1:0]           data_out,
    output logic [D_SIZE-1:0]           data_in,
    output logic                        stall,
    output logic [$clog2(WB_DEPTH):0]   wb_count
);
    localparam int MEM_WORDS = 1 << A_SIZE;
    localparam int PW        = $clog2(WB_DEPTH);
    localparam int CW        = PW + 1;

    typedef logic [D_SIZE-1:0] mem_t [MEM_WORDS];

    function automatic mem_t mem_init();
        mem_t m;
        for (int i = 0; i < MEM_WORDS; i++) begin
            m[i] = D_SIZE'(i);
        end
        return m;
    endfunction

    mem_t                mem_r = mem_init();
    logic [A_SIZE-1:0]   wb_addr_r [WB_DEPTH];
    logic [D_SIZE-1:0]   wb_data_r [WB_DEPTH];
    logic [PW-1:0]       head_r;
    logic [PW-1:0]       tail_r;
    logic [CW-1:0]       count_r;

    logic                rd_only_s;
    logic                wr_only_s;
    logic                full_s;
    logic                hit_s;
    logic [D_SIZE-1:0]   hit_data_s;
    logic                load_port_s;
    logic                load_stall_s;
    logic                enq_s;
    logic                drain_s;
    logic [PW-1:0]       idx_s;

    // Request decode and youngest-match search over the pending stores.
    always_comb begin
        rd_only_s  = read & ~write;
        wr_only_s  = write & ~read;
        full_s     = (count_r == CW'(WB_DEPTH));
        hit_s      = 1'b0;
        hit_data_s = {D_SIZE{1'b0}};
        idx_s      = {PW{1'b0}};
        // Walking oldest to youngest lets the last hit win.
        for (int k = 0; k < WB_DEPTH; k++) begin
            idx_s = head_r + PW'(k);
            if ((CW'(k) < count_r) && (wb_addr_r[idx_s] == address)) begin
                hit_s      = 1'b1;
                hit_data_s = wb_data_r[idx_s];
            end else begin
                hit_s      = hit_s;
                hit_data_s = hit_data_s;
            end
        end
`ifdef DMEM_FWD_EN
        load_stall_s = 1'b0;
        load_port_s  = rd_only_s;
`else
        load_stall_s = rd_only_s & hit_s;
        load_port_s  = rd_only_s & ~hit_s;
`endif
        stall   = ~rst & ((wr_only_s & full_s) | load_stall_s);
        enq_s   = ~rst & wr_only_s & ~full_s;
        drain_s = ~rst & (count_r != {CW{1'b0}}) & ~load_port_s;
    end

    // Load data path: zero unless a load is actually being served.
    always_comb begin
        data_in = {D_SIZE{1'b0}};
        if (rst || !rd_only_s || load_stall_s) begin
            data_in = {D_SIZE{1'b0}};
        end else if (hit_s) begin
            data_in = hit_data_s;
        end else begin
            data_in = mem_r[address];
        end
    end

    // Buffer pointers and occupancy.
    always_ff @(posedge clk) begin
        if (rst) begin
            head_r  <= {PW{1'b0}};
            tail_r  <= {PW{1'b0}};
            count_r <= {CW{1'b0}};
        end else begin
            if (enq_s) begin
                tail_r <= tail_r + {{(PW-1){1'b0}}, 1'b1};
            end
            if (drain_s) begin
                head_r <= head_r + {{(PW-1){1'b0}}, 1'b1};
            end
            case ({enq_s, drain_s})
                2'b10:   count_r <= count_r + {{(CW-1){1'b0}}, 1'b1};
                2'b01:   count_r <= count_r - {{(CW-1){1'b0}}, 1'b1};
                default: count_r <= count_r;
            endcase
        end
    end

    // Buffer entry storage; contents are don't-care outside the head..tail window.
    always_ff @(posedge clk) begin
        if (enq_s) begin
            wb_addr_r[tail_r] <= address;
            wb_data_r[tail_r] <= data_out;
        end
    end

    // Array write port: retire the head entry.
    always_ff @(posedge clk) begin
        if (drain_s) begin
            mem_r[wb_addr_r[head_r]] <= wb_data_r[head_r];
        end
    end

    assign wb_count = count_r;

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Self-checking bench for data_mem_ctrl: reference model of array plus pending-store queue, load scoreboard.
module tb_data_mem_ctrl;
    localparam int A_SIZE   = 10;
    localparam int D_SIZE   = 32;
    localparam int WB_DEPTH = 4;
    localparam int CW       = $clog2(WB_DEPTH) + 1;
`ifdef DMEM_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic                clk = 1'b0;
    logic                rst;
    logic                read;
    logic                write;
    logic [A_SIZE-1:0]   address;
    logic [D_SIZE-1:0]   data_out;
    logic [D_SIZE-1:0]   data_in;
    logic                stall;
    logic [CW-1:0]       wb_count;

    always #5 clk = ~clk;

    data_mem_ctrl #(.A_SIZE(A_SIZE), .D_SIZE(D_SIZE), .WB_DEPTH(WB_DEPTH)) dut (
        .clk(clk), .rst(rst), .read(read), .write(write), .address(address),
        .data_out(data_out), .data_in(data_in), .stall(stall), .wb_count(wb_count)
    );

    typedef struct packed {
        logic [A_SIZE-1:0] a;
        logic [D_SIZE-1:0] d;
    } wb_ent_t;

    int                n_cmp = 0;
    int                n_err = 0;
    logic [D_SIZE-1:0] model_mem [1 << A_SIZE];
    wb_ent_t           pend_q [$];
    logic [D_SIZE-1:0] exp_q [$];

    task automatic check_val(input string tag, input logic [D_SIZE-1:0] obs, input logic [D_SIZE-1:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [D_SIZE-1:0] model_read(input logic [A_SIZE-1:0] a);
        logic [D_SIZE-1:0] v;
        v = model_mem[a];
        foreach (pend_q[i]) if (pend_q[i].a == a) v = pend_q[i].d;
        return v;
    endfunction

    function automatic bit model_hit(input logic [A_SIZE-1:0] a);
        bit h;
        h = 1'b0;
        foreach (pend_q[i]) if (pend_q[i].a == a) h = 1'b1;
        return h;
    endfunction

    // One clock of stimulus: drive, check against the model, then advance the model at the edge.
    task automatic step(input bit r, input bit w, input bit rs, input logic [A_SIZE-1:0] a,
                        input logic [D_SIZE-1:0] d, output bit st, output logic [D_SIZE-1:0] q);
        bit rd_only, wr_only, full, exp_stall, port_used;
        wb_ent_t ent;
        rst = rs; read = r; write = w; address = a; data_out = d;
        #2;
        rd_only   = r && !w;
        wr_only   = w && !r;
        full      = (pend_q.size() == WB_DEPTH);
        exp_stall = !rs && ((wr_only && full) || (!FWD && rd_only && model_hit(a)));
        port_used = !rs && rd_only && !exp_stall;
        check_val("wb_count", D_SIZE'(wb_count), D_SIZE'(pend_q.size()));
        check_val("stall", D_SIZE'(stall), D_SIZE'(exp_stall));
        if (rs || !rd_only) check_val("data_in_zero", data_in, {D_SIZE{1'b0}});
        st = stall;
        q  = data_in;
        @(posedge clk);
        if (rs) begin
            pend_q.delete();
        end else begin
            if (pend_q.size() > 0 && !port_used) begin
                ent = pend_q.pop_front();
                model_mem[ent.a] = ent.d;
            end
            if (wr_only && !full) pend_q.push_back(wb_ent_t'({a, d}));
        end
        #1;
    endtask

    task automatic do_load(input logic [A_SIZE-1:0] a);
        bit st;
        logic [D_SIZE-1:0] q;
        exp_q.push_back(model_read(a));
        for (int c = 0; c < 8; c++) begin
            step(1'b1, 1'b0, 1'b0, a, {D_SIZE{1'b0}}, st, q);
            if (!st) begin
                check_val("load_data", q, exp_q.pop_front());
                return;
            end
        end
        check_val("load_timeout", D_SIZE'(st), {D_SIZE{1'b0}});
        void'(exp_q.pop_front());
    endtask

    task automatic do_store(input logic [A_SIZE-1:0] a, input logic [D_SIZE-1:0] d);
        bit st;
        logic [D_SIZE-1:0] q;
        for (int c = 0; c < 8; c++) begin
            step(1'b0, 1'b1, 1'b0, a, d, st, q);
            if (!st) return;
        end
        check_val("store_timeout", D_SIZE'(st), {D_SIZE{1'b0}});
    endtask

    task automatic idle(input int n);
        bit st;
        logic [D_SIZE-1:0] q;
        for (int c = 0; c < n; c++) step(1'b0, 1'b0, 1'b0, {A_SIZE{1'b0}}, {D_SIZE{1'b0}}, st, q);
    endtask

    task automatic do_reset(input int n);
        bit st;
        logic [D_SIZE-1:0] q;
        // Requests during reset must be ignored.
        for (int c = 0; c < n; c++) step(1'b1, 1'b0, 1'b1, A_SIZE'(5), {D_SIZE{1'b0}}, st, q);
    endtask

    initial begin
        bit st;
        logic [D_SIZE-1:0] q;
        for (int i = 0; i < (1 << A_SIZE); i++) model_mem[i] = D_SIZE'(i);
        rst = 1'b1; read = 1'b0; write = 1'b0; address = {A_SIZE{1'b0}}; data_out = {D_SIZE{1'b0}};
        @(posedge clk);
        #1;
        pend_q.delete();
        do_reset(2);

        do_load(A_SIZE'(5));

        do_store(A_SIZE'(3), 32'h0000_0011);
        idle(1);
        do_load(A_SIZE'(3));

        for (int i = 0; i < 4; i++) begin
            do_store(A_SIZE'(40 + i), D_SIZE'(32'h100 + i));
            do_load(A_SIZE'(100));
        end
        do_store(A_SIZE'(44), 32'h0000_0104);
        idle(2);

        do_store(A_SIZE'(7), 32'h0000_00AA);
        do_store(A_SIZE'(7), 32'h0000_00BB);
        do_load(A_SIZE'(7));

        do_store(A_SIZE'(20), 32'h0000_0200);
        do_store(A_SIZE'(21), 32'h0000_0201);
        do_store(A_SIZE'(22), 32'h0000_0202);
        do_reset(1);
        do_load(A_SIZE'(20));
        do_load(A_SIZE'(21));
        do_load(A_SIZE'(22));

        step(1'b1, 1'b1, 1'b0, A_SIZE'(9), 32'h0000_0999, st, q);
        idle(2);
        do_load(A_SIZE'(9));

        for (int n = 0; n < 60; n++) begin
            case ($urandom_range(0, 3))
                0: do_load(A_SIZE'($urandom_range(0, 7)));
                1: do_store(A_SIZE'($urandom_range(0, 7)), D_SIZE'($urandom));
                2: idle(1);
                default: step(1'b1, 1'b1, 1'b0, A_SIZE'($urandom_range(0, 7)), D_SIZE'($urandom), st, q);
            endcase
        end
        idle(3);
        for (int i = 0; i < 8; i++) do_load(A_SIZE'(i));
        do_load(A_SIZE'(40));
        do_load(A_SIZE'(44));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
